// File: rtl/keypad_pkg.sv
// Shared constants, FSM state type and frame classification helper for the
// 4x4 keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = NUM_ROWS * NUM_COLS;

  localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } state_e;

  // True when exactly one key bit is set (popcount == 1).
  function automatic logic is_single(input logic [KEY_W-1:0] f);
    return (f != '0) && ((f & (f - KEY_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Parameterised-width two-flop synchronizer with asynchronous active-low reset.
module keypad_sync #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates the column drive, assembles one frame per
// full scan and debounces single-key presses and releases into a one-hot code.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_n,
  output logic [KEY_W-1:0]    onehot,
  output logic                key_valid,
  output logic                key_held,
  output logic [1:0]          dbg_state
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_SCANS);

  logic [NUM_ROWS-1:0] row_sync;

  logic [SLOT_W-1:0]   slot_q;
  logic [1:0]          col_idx_q;
  logic [NUM_COLS-1:0] col_n_q;
  logic [KEY_W-1:0]    frame_q;
  logic [KEY_W-1:0]    frame_d;
  logic                slot_end;
  logic                frame_done;

  state_e              state_q;
  logic [KEY_W-1:0]    cand_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [KEY_W-1:0]    onehot_q;
  logic                valid_q;
  logic                held_q;

  keypad_sync #(
    .W       (NUM_ROWS),
    .RST_VAL ({NUM_ROWS{1'b1}})
  ) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (row_n),
    .q_o   (row_sync)
  );

  assign slot_end   = (slot_q == SLOT_LAST);
  assign frame_done = slot_end && (col_idx_q == 2'd3);

  // Frame contents including the column being sampled this cycle.
  always_comb begin
    frame_d = frame_q;
    if (slot_end) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        frame_d[r*NUM_COLS + int'(col_idx_q)] = ~row_sync[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q    <= '0;
      col_idx_q <= 2'd0;
      col_n_q   <= COL_RESET;
      frame_q   <= '0;
    end else if (slot_end) begin
      slot_q    <= '0;
      col_idx_q <= col_idx_q + 2'd1;
      col_n_q   <= {col_n_q[NUM_COLS-2:0], col_n_q[NUM_COLS-1]};
      frame_q   <= frame_done ? '0 : frame_d;
    end else begin
      slot_q    <= slot_q + SLOT_W'(1);
    end
  end

  // Debounce FSM; decisions on frame data are taken only at frame completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      onehot_q <= '0;
      valid_q  <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_done && is_single(frame_d)) begin
            cand_q  <= frame_d;
            cnt_q   <= CNT_W'(1);
            state_q <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (cnt_q == CNT_MAX) begin
            onehot_q <= cand_q;
            valid_q  <= 1'b1;
            held_q   <= 1'b1;
            cnt_q    <= '0;
            state_q  <= PRESSED;
          end else if (frame_done) begin
            if (frame_d == cand_q) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end else begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end
          end
        end
        PRESSED: begin
          if (cnt_q == CNT_MAX) begin
            held_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (frame_done) begin
            if (frame_d == '0) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end else begin
              cnt_q <= '0;
            end
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign col_n     = col_n_q;
  assign onehot    = onehot_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a matrix keypad model and a
// key_valid scoreboard that pops expected one-hot codes.
module tb_keypad_scanner;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 3;
  localparam int FRAME          = 4 * SCAN_DIV;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] onehot;
  logic        key_valid;
  logic        key_held;
  logic [1:0]  dbg_state;

  logic [15:0] keys;
  logic [15:0] exp_q[$];
  logic [15:0] prev_oh;
  int          n_cmp;
  int          n_fail;
  int          vld_cnt;
  int          vld_cyc;
  int          cyc;
  int          base;
  int          t0;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .onehot    (onehot),
    .key_valid (key_valid),
    .key_held  (key_held),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Keypad matrix: a pressed key shorts its row to its column while driven low.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[4*r + c] && !col_n[c]) row_n[r] = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: key_valid (handshake: one-cycle pulse, onehot valid in same cycle)
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid) begin
        vld_cnt++;
        vld_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {16'h0, onehot}, 32'hffff_ffff);
        end else begin
          chk("valid_onehot", {16'h0, onehot}, {16'h0, exp_q.pop_front()});
        end
      end
      if (onehot !== prev_oh) chk("onehot_change_needs_valid", {31'h0, key_valid}, 32'd1);
    end
    prev_oh = onehot;
  end

  initial begin
    n_cmp = 0; n_fail = 0; vld_cnt = 0; vld_cyc = 0; cyc = 0;
    keys = '0; rst_n = 1'b0; prev_oh = '0;

    // 1 Reset
    wait_cycles(2);
    chk("rst_col_n", {28'h0, col_n}, 32'he);
    chk("rst_onehot", {16'h0, onehot}, 32'h0);
    chk("rst_state", {30'h0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    wait_cycles(6);
    @(posedge clk); #3 rst_n = 1'b0; #1;
    chk("async_rst_col_n", {28'h0, col_n}, 32'he);
    chk("async_rst_valid_held", {30'h0, key_valid, key_held}, 32'd0);
    chk("async_rst_onehot", {16'h0, onehot}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("scan_col_hold", {28'h0, col_n}, 32'he);
    @(posedge clk); #1;
    chk("scan_col_1", {28'h0, col_n}, 32'hd);
    repeat (4) @(posedge clk); #1;
    chk("scan_col_2", {28'h0, col_n}, 32'hb);
    @(negedge clk);

    // 2 Clean press row 1 / col 2
    base = vld_cnt;
    exp_q.push_back(16'h0040);
    keys = 16'h0040; t0 = cyc;
    wait_cycles(8 * FRAME);
    chk("t2_pulses", vld_cnt - base, 1);
    chk("t2_latency_ok", {31'h0, (vld_cyc - t0) <= (DEBOUNCE_SCANS + 1) * FRAME + 3}, 32'd1);
    chk("t2_held", {31'h0, key_held}, 32'd1);
    chk("t2_state", {30'h0, dbg_state}, 32'd2);
    keys = '0;
    wait_cycles(5 * FRAME);
    chk("t2_released", {31'h0, key_held}, 32'd0);
    chk("t2_onehot_kept", {16'h0, onehot}, 32'h0040);

    // 3 Bounce on row 3 / col 3
    base = vld_cnt;
    for (int i = 0; i < 3; i++) begin
      keys = 16'h8000;
      wait_cycles(2 * FRAME);
      keys = '0;
      wait_cycles(2 * FRAME);
    end
    chk("t3_no_pulse", vld_cnt - base, 0);
    chk("t3_onehot", {16'h0, onehot}, 32'h0040);
    chk("t3_state", {30'h0, dbg_state}, 32'd0);

    // 4 Multi-key on col 1, then single
    base = vld_cnt;
    keys = 16'h0202;
    wait_cycles(3 * FRAME);
    chk("t4_state_mid", {30'h0, dbg_state}, 32'd0);
    wait_cycles(3 * FRAME);
    chk("t4_no_pulse", vld_cnt - base, 0);
    chk("t4_state", {30'h0, dbg_state}, 32'd0);
    exp_q.push_back(16'h0002);
    keys = 16'h0002;
    wait_cycles(6 * FRAME);
    chk("t4_pulse", vld_cnt - base, 1);
    chk("t4_onehot", {16'h0, onehot}, 32'h0002);
    keys = '0;
    wait_cycles(5 * FRAME);

    // 5 Hold, switch, release, new key
    base = vld_cnt;
    exp_q.push_back(16'h0008);
    keys = 16'h0008;
    wait_cycles(10 * FRAME);
    chk("t5_first_pulse", vld_cnt - base, 1);
    keys = 16'h0108;
    wait_cycles(4 * FRAME);
    chk("t5_switch_no_pulse", vld_cnt - base, 1);
    chk("t5_switch_held", {31'h0, key_held}, 32'd1);
    keys = '0;
    wait_cycles(5 * FRAME);
    chk("t5_idle", {30'h0, dbg_state}, 32'd0);
    exp_q.push_back(16'h8000);
    keys = 16'h8000;
    wait_cycles(8 * FRAME);
    chk("t5_second_pulse", vld_cnt - base, 2);
    chk("t5_onehot", {16'h0, onehot}, 32'h8000);

    // 6 Short release while PRESSED
    base = vld_cnt;
    keys = '0;
    wait_cycles(2 * FRAME);
    chk("t6_held_during_gap", {31'h0, key_held}, 32'd1);
    keys = 16'h8000;
    wait_cycles(4 * FRAME);
    chk("t6_no_pulse", vld_cnt - base, 0);
    chk("t6_held", {31'h0, key_held}, 32'd1);
    chk("t6_onehot", {16'h0, onehot}, 32'h8000);

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
